// File: rtl/apb_bridge_master.sv
// Single-outstanding APB master: valid/ready command in, SETUP/ACCESS transfer out, response with read data back.
// Optional ACCESS wait-state timeout enabled by defining APB_BRIDGE_MASTER_TIMEOUT_EN.
module apb_bridge_master #(
    parameter int ADDWIDTH       = 8,
    parameter int DATAWIDTH      = 32,
    parameter int RDATA_LAT      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDWIDTH-1:0]    cmd_addr,
    input  logic [DATAWIDTH-1:0]   cmd_wdata,
    input  logic [DATAWIDTH/8-1:0] cmd_strb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATAWIDTH-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [ADDWIDTH-1:0]    PADDR,
    output logic [DATAWIDTH/8-1:0] PSTRB,
    output logic [DATAWIDTH-1:0]   PWDATA,
    input  logic                   PREADY,
    input  logic [DATAWIDTH-1:0]   PRDATA
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, RESP} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   timeout_hit;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = PRESETn;
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    if (PWRITE || RDATA_LAT == 0) state_nxt = RESP;
                    else                          state_nxt = CAPTURE;
                end else if (timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            CAPTURE: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PSTRB     <= '0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                PWRITE    <= cmd_write;
                PADDR     <= cmd_addr;
                PSTRB     <= cmd_write ? cmd_strb : '0;
                rsp_rdata <= '0;
                if (cmd_write) PWDATA <= cmd_wdata;
            end
            // Zero-latency slaves are sampled on the completing edge, registered ones one edge later
            if (state == ACCESS && PREADY && !PWRITE && RDATA_LAT == 0) rsp_rdata <= PRDATA;
            if (state == CAPTURE) rsp_rdata <= PRDATA;
        end
    end

`ifdef APB_BRIDGE_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    // Abort on the edge that completes the TIMEOUT_CYCLES-th wait state
    assign timeout_hit = (state == ACCESS) && !PREADY && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tcnt    <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == SETUP)                  tcnt <= '0;
            else if (state == ACCESS && !PREADY) tcnt <= tcnt + 1'b1;
            if (accept)           rsp_err <= 1'b0;
            else if (timeout_hit) rsp_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: doc/apb_bridge_master.md
# apb_bridge_master

Single-outstanding APB master that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns a response with read data. Sits directly upstream of the team's APB memory slave (`slave1`-style targets: combinational PREADY, registered PRDATA), driving PSEL/PENABLE/PWRITE/PADDR/PSTRB/PWDATA and collecting PRDATA.

## Interface
- ADDWIDTH, 8, APB address width
- DATAWIDTH, 32, APB data width; multiple of 8
- RDATA_LAT, 1, cycles after the completing ACCESS edge before PRDATA is valid (0 or 1)
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low (used only with timeout feature)

- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDWIDTH  target address
- cmd_wdata  in  DATAWIDTH  write data
- cmd_strb  in  DATAWIDTH/8  byte strobes (forced to 0 on reads)
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at edge
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and errors
- rsp_err  out  1  transfer timed out
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDWIDTH; PSTRB  out  DATAWIDTH/8; PWDATA  out  DATAWIDTH
- PREADY  in  1; PRDATA  in  DATAWIDTH

## Operation
- States: IDLE, SETUP, ACCESS, CAPTURE, RESP.
- IDLE: cmd_ready=1. On accept, register write/addr/wdata/strb into APB output registers -> SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1; APB outputs stable. PREADY=1 at edge: write -> RESP; read -> CAPTURE if RDATA_LAT=1, else latch PRDATA -> RESP. PREADY=0 -> stay (wait states).
- CAPTURE: PSEL=0, PENABLE=0; latch PRDATA into rsp_rdata at edge -> RESP.
- RESP: rsp_valid=1; on rsp_ready -> IDLE. cmd_ready=0 (no command accepted in same cycle as response pop; one IDLE cycle minimum between transfers).
- Outside SETUP/ACCESS: PSEL=PENABLE=0; PADDR/PWRITE/PWDATA/PSTRB hold last values.
- Reads drive PSTRB=0, PWDATA unchanged.

## Timing
- Reset (PRESETn=0 at edge): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, rsp_valid, rsp_rdata, rsp_err all 0; cmd_ready=0 during reset cycle, 1 the cycle after.
- Reset mid-transfer: transfer abandoned, no response produced, bus idle next cycle.
- Zero-wait write: accept edge E0; SETUP E0–E1; ACCESS E1–E2; rsp_valid high after E2 (latency 2 edges).
- Zero-wait read, RDATA_LAT=1: rsp_valid after E3 with rsp_rdata = PRDATA sampled at E3. RDATA_LAT=0: after E2.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- cmd_* ignored outside IDLE; cmd_valid may drop without acceptance.

## Configuration
- APB_BRIDGE_MASTER_TIMEOUT_EN defined: counter increments each ACCESS cycle with PREADY=0, cleared on SETUP; when count reaches TIMEOUT_CYCLES, abort: PSEL/PENABLE drop next cycle, -> RESP with rsp_err=1, rsp_rdata=0.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err tied 0.

## Test plan
- Reset: hold PRESETn=0 two cycles with cmd_valid=1 -> all outputs 0, no PSEL; cmd_ready=1 first cycle after release.
- Write addr 0x10, data 0xDEADBEEF, strb 0xF -> SETUP/ACCESS on consecutive cycles, PREADY high in ACCESS, rsp_valid after 2 edges, rsp_rdata=0, rsp_err=0.
- Read back 0x10 with slave (RDATA_LAT=1) -> rsp_rdata=0xDEADBEEF after 3 edges, PSTRB=0 during transfer.
- PREADY held low 3 ACCESS cycles -> PENABLE high 4 cycles, outputs stable, response delayed by 3; rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0.
- With APB_BRIDGE_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck low -> abort after 4 wait cycles, rsp_err=1, rsp_rdata=0; without macro, transfer still pending after 100 cycles.
- PRESETn low during ACCESS -> PSEL=0 next cycle, no rsp_valid, next command completes normally.
